state_demux_1x4: RTL and testbench

Registered 1-to-4 demultiplexer for the 320-bit cipher state: a single producer hands a word plus a 2-bit destination select, and the block routes it into one of four output holding registers, or into all four in broadcast mode. It is the distribution counterpart of the 4-to-1 state selector. It sits between the permutation datapath and the four state consumers, with valid/ready flow control on every side. One holding register per destination decouples consumers from each other, so a stalled consumer blocks only traffic addressed to it.

---
 rtl/state_demux_1x4_pkg.sv | 22 ++
 rtl/state_demux_1x4_slot.sv | 62 ++++++
 rtl/state_demux_1x4.sv | 77 +++++++
 tb/tb_state_demux_1x4.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/state_demux_1x4_pkg.sv
// state_pkg: shared types for the cipher-state distribution path.
//   STATE_W   - width of one cipher state word
//   state_t   - one cipher state word
//   dest_t    - destination index of the 1-to-4 demux
//   dest_mask - one-hot (or all-ones for broadcast) slot target mask
package state_pkg;

    localparam int STATE_W = 320;

    typedef logic [STATE_W-1:0] state_t;
    typedef logic [1:0]         dest_t;

    function automatic logic [3:0] dest_mask(input dest_t sel, input logic bcast);
        logic [3:0] m;
        m = 4'b0001 << sel;
        if (bcast) begin
            m = 4'b1111;
        end
        return m;
    endfunction

endpackage

// File: rtl/state_demux_1x4_slot.sv
// demux_slot: one destination of the state demux. Holds the data word, its
// valid flag and a modulo-2^cnt_w count of words taken by the consumer.
// Ports:
//   clk, rst_n   - clock, async active-low reset
//   d            - word to load when push is high
//   push         - load d and mark the slot valid
//   ready        - consumer takes q this cycle when valid is high
//   q            - held word (kept after it is taken)
//   valid        - slot holds an undelivered word
//   can_accept   - slot is empty or being emptied this cycle
//   cnt          - number of words delivered, wrapping
module demux_slot
    import state_pkg::*;
#(
    parameter int width = STATE_W,
    parameter int cnt_w = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] d,
    input  logic             push,
    input  logic             ready,
    output logic [width-1:0] q,
    output logic             valid,
    output logic             can_accept,
    output logic [cnt_w-1:0] cnt
);

    logic [width-1:0] r_data;
    logic             r_valid;
    logic [cnt_w-1:0] r_cnt;
    logic             w_pop;

    assign w_pop      = r_valid & ready;
    assign can_accept = ~r_valid | ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (push) begin
                r_data <= d;
            end
            // A push wins over a pop: the slot stays full with the new word.
            if (push) begin
                r_valid <= 1'b1;
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end
            if (w_pop) begin
                r_cnt <= r_cnt + cnt_w'(1);
            end
        end
    end

    assign q     = r_data;
    assign valid = r_valid;
    assign cnt   = r_cnt;

endmodule

// File: rtl/state_demux_1x4.sv
// state_demux_1x4: registered 1-to-4 demultiplexer for the cipher state.
// A producer offers x with a destination sel (or bcast to all four); each
// destination has its own holding register so a stalled consumer only blocks
// traffic addressed to it.
// Ports:
//   clk, rst_n        - clock, async active-low reset
//   x, sel, bcast     - incoming word, destination, broadcast request
//   in_valid/in_ready - producer handshake (in_ready is combinational)
//   x_0..x_3          - holding-register contents
//   out_valid         - bit i set when x_i holds an undelivered word
//   out_ready         - consumer i takes x_i on out_valid[i] & out_ready[i]
//   cnt_0..cnt_3      - words delivered per output, wrapping
module state_demux_1x4
    import state_pkg::*;
#(
    parameter int width = STATE_W,
    parameter int cnt_w = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] x,
    input  dest_t            sel,
    input  logic             bcast,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [width-1:0] x_0,
    output logic [width-1:0] x_1,
    output logic [width-1:0] x_2,
    output logic [width-1:0] x_3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [cnt_w-1:0] cnt_0,
    output logic [cnt_w-1:0] cnt_1,
    output logic [cnt_w-1:0] cnt_2,
    output logic [cnt_w-1:0] cnt_3
);

    logic [3:0]       w_mask;
    logic [3:0]       w_can;
    logic [3:0]       w_push;
    logic [width-1:0] w_x   [4];
    logic [cnt_w-1:0] w_cnt [4];

    assign w_mask = dest_mask(sel, bcast);

    // Every targeted slot must be able to take the word; non-targeted slots
    // are masked to 1. Unicast reduces to w_can[sel], broadcast to &w_can.
    assign in_ready = &(~w_mask | w_can);
    assign w_push   = w_mask & {4{in_valid & in_ready}};

    for (genvar i = 0; i < 4; i++) begin : g_slot
        demux_slot #(
            .width (width),
            .cnt_w (cnt_w)
        ) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .d          (x),
            .push       (w_push[i]),
            .ready      (out_ready[i]),
            .q          (w_x[i]),
            .valid      (out_valid[i]),
            .can_accept (w_can[i]),
            .cnt        (w_cnt[i])
        );
    end

    assign x_0   = w_x[0];
    assign x_1   = w_x[1];
    assign x_2   = w_x[2];
    assign x_3   = w_x[3];
    assign cnt_0 = w_cnt[0];
    assign cnt_1 = w_cnt[1];
    assign cnt_2 = w_cnt[2];
    assign cnt_3 = w_cnt[3];

endmodule

// File: tb/tb_state_demux_1x4.sv
module tb_state_demux_1x4;

    localparam int W  = 320;
    localparam int CW = 8;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  x;
    logic [1:0]    sel;
    logic          bcast;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  x_0, x_1, x_2, x_3;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [CW-1:0] cnt_0, cnt_1, cnt_2, cnt_3;

    int n_checks = 0;
    int n_fail   = 0;

    state_demux_1x4 #(.width(W), .cnt_w(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x         (x),
        .sel       (sel),
        .bcast     (bcast),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_0       (x_0),
        .x_1       (x_1),
        .x_2       (x_2),
        .x_3       (x_3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cnt_0     (cnt_0),
        .cnt_1     (cnt_1),
        .cnt_2     (cnt_2),
        .cnt_3     (cnt_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] xv;
        logic [1:0]  sel;
        logic        bcast;
        logic        valid;
        logic [3:0]  oready;
        logic        exp_rdy;
        logic [3:0]  exp_ov;
        logic [1:0]  chk;
        logic [15:0] exp_x;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] slot_x(input logic [1:0] i);
        case (i)
            2'd0:    return x_0;
            2'd1:    return x_1;
            2'd2:    return x_2;
            default: return x_3;
        endcase
    endfunction

    function automatic logic [CW-1:0] slot_cnt(input logic [1:0] i);
        case (i)
            2'd0:    return cnt_0;
            2'd1:    return cnt_1;
            2'd2:    return cnt_2;
            default: return cnt_3;
        endcase
    endfunction

    task automatic idle_inputs();
        x         = '0;
        sel       = 2'd0;
        bcast     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 4'b0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        // vectors: one cycle each, starting from an empty block
        vecs[0] = '{16'h1234, 2'd2, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b0100, 2'd2, 16'h1234};
        vecs[1] = '{16'h0000, 2'd0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 2'd2, 16'h1234};
        vecs[2] = '{16'h1111, 2'd1, 1'b0, 1'b1, 4'b1101, 1'b1, 4'b0010, 2'd1, 16'h1111};
        vecs[3] = '{16'h2222, 2'd1, 1'b0, 1'b1, 4'b1101, 1'b0, 4'b0010, 2'd1, 16'h1111};
        vecs[4] = '{16'h3333, 2'd3, 1'b0, 1'b1, 4'b1101, 1'b1, 4'b1010, 2'd3, 16'h3333};
        vecs[5] = '{16'h4444, 2'd0, 1'b0, 1'b1, 4'b0100, 1'b1, 4'b1011, 2'd0, 16'h4444};
        vecs[6] = '{16'hA5A5, 2'd2, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b1011, 2'd0, 16'h4444};
        vecs[7] = '{16'hA5A5, 2'd2, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b1111, 2'd1, 16'hA5A5};
        vecs[8] = '{16'h0000, 2'd0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 2'd3, 16'hA5A5};

        // reset and idle
        do_reset();
        #1;
        check("reset_out_valid", W'(out_valid), W'(4'b0000));
        for (int i = 0; i < 4; i++) begin
            check("reset_cnt", W'(slot_cnt(2'(i))), '0);
            check("reset_x", slot_x(2'(i)), '0);
            sel = 2'(i);
            #1;
            check("reset_in_ready", W'(in_ready), W'(1'b1));
        end

        // table-driven directed vectors
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            x         = W'(vecs[i].xv);
            sel       = vecs[i].sel;
            bcast     = vecs[i].bcast;
            in_valid  = vecs[i].valid;
            out_ready = vecs[i].oready;
            #1;
            check($sformatf("vec%0d_in_ready", i), W'(in_ready), W'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_out_valid", i), W'(out_valid), W'(vecs[i].exp_ov));
            check($sformatf("vec%0d_x", i), slot_x(vecs[i].chk), W'(vecs[i].exp_x));
        end
        // slot 2: popped in vec1 and vec8; slots 0,1,3: popped in vec7 and vec8
        for (int i = 0; i < 4; i++) begin
            check($sformatf("table_cnt%0d", i), W'(slot_cnt(2'(i))), W'(8'd2));
        end
        check("bcast_x0", x_0, W'(16'hA5A5));
        check("bcast_x2", x_2, W'(16'hA5A5));

        // same-cycle pop/push streaming on slot 0
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            x         = W'(16'h0100 + k);
            sel       = 2'd0;
            bcast     = 1'b0;
            in_valid  = 1'b1;
            out_ready = 4'b0001;
            #1;
            check("stream_in_ready", W'(in_ready), W'(1'b1));
            @(posedge clk);
            #1;
            check("stream_out_valid0", W'(out_valid[0]), W'(1'b1));
        end
        check("stream_last_x0", x_0, W'(16'h010A));
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("stream_cnt0", W'(cnt_0), W'(8'd10));
        check("stream_drained", W'(out_valid), W'(4'b0000));
        check("stream_x0_kept", x_0, W'(16'h010A));

        // counter wrap on slot 3
        do_reset();
        for (int k = 0; k < 257; k++) begin
            @(negedge clk);
            x         = W'(k);
            sel       = 2'd3;
            in_valid  = 1'b1;
            out_ready = 4'b1000;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("wrap_cnt3", W'(cnt_3), W'(8'd1));
        check("wrap_x3", x_3, W'(16'd256));

        // fill all slots, then async reset between clock edges
        @(negedge clk);
        x         = W'(16'hBEEF);
        bcast     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 4'b0000;
        @(posedge clk);
        #1;
        check("fill_out_valid", W'(out_valid), W'(4'b1111));
        in_valid = 1'b0;
        bcast    = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", W'(out_valid), W'(4'b0000));
        check("async_cnt3", W'(cnt_3), '0);
        check("async_x3", x_3, '0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
